// File: rtl/div_iter_unit_pkg.sv
// Shared types and op encodings for the iterative divide/remainder unit.
// DIV_EARLY_OUT_EN adds the leading-zero helper used by the early-out build.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_type;

    localparam logic [1:0] div_op_div  = 2'b00;
    localparam logic [1:0] div_op_divu = 2'b01;
    localparam logic [1:0] div_op_rem  = 2'b10;
    localparam logic [1:0] div_op_remu = 2'b11;

`ifdef DIV_EARLY_OUT_EN
    // Leading zeros of val[width-1:0]; width is at most 64.
    function automatic int unsigned div_lzc(input logic [63:0] val, input int unsigned width);
        int unsigned n;
        logic found;
        n = 0;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < int'(width) && !found) begin
                if (val[i]) begin
                    found = 1'b1;
                end else begin
                    n++;
                end
            end
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/div_iter_unit_if.sv
// Execute-stage handshake of the divider: request side driven by master, response by slave.
interface div_iter_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            enable;
    logic [1:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] result;
    logic            ready;
    logic            busy;

    modport master (
        output enable, op, rdata1, rdata2,
        input  result, ready, busy
    );

    modport slave (
        input  enable, op, rdata1, rdata2,
        output result, ready, busy
    );
endinterface

// File: rtl/div_iter_step.sv
// One combinational restoring-division step: shift a dividend bit into rem, retire one quotient bit.
module div_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor always holds, so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (diff[XLEN]) begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_iter_unit.sv
// Iterative RV32M/RV64M divide/remainder unit retiring BITS_PER_CYCLE quotient bits per cycle.
// Optional DIV_EARLY_OUT_EN skips leading-zero groups of the dividend at start.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic             clock,
    input logic             reset,
    div_iter_unit_if.slave  bus
);
    localparam int unsigned Steps = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CntW  = $clog2(Steps + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Steps);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

    typedef struct packed {
        div_state_type   state;
        logic [CntW-1:0] cnt;
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] divisor;
        logic            sign1;
        logic            sign2;
        logic [1:0]      op;
        logic [XLEN-1:0] result;
        logic            ready;
    } div_reg_type;

    localparam div_reg_type init_div_reg = '0;

    div_reg_type r, rin;

    logic [XLEN-1:0] dividend_abs;
    logic [XLEN-1:0] divisor_abs;
    logic [XLEN-1:0] rem_last;
    logic [XLEN-1:0] quo_last;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
`ifdef DIV_EARLY_OUT_EN
    int unsigned lz_groups;
`endif

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [XLEN-1:0] rem_in, quo_in, rem_out, quo_out;
        if (i == 0) begin : g_first
            assign rem_in = r.rem;
            assign quo_in = r.quo;
        end else begin : g_next
            assign rem_in = g_step[i-1].rem_out;
            assign quo_in = g_step[i-1].quo_out;
        end
        div_iter_step #(
            .XLEN (XLEN)
        ) u_step (
            .rem      (rem_in),
            .quo      (quo_in),
            .divisor  (r.divisor),
            .rem_next (rem_out),
            .quo_next (quo_out)
        );
    end

    assign rem_last = g_step[BITS_PER_CYCLE-1].rem_out;
    assign quo_last = g_step[BITS_PER_CYCLE-1].quo_out;

    always_comb begin
        dividend_abs = (!bus.op[0] && bus.rdata1[XLEN-1]) ? -bus.rdata1 : bus.rdata1;
        divisor_abs  = (!bus.op[0] && bus.rdata2[XLEN-1]) ? -bus.rdata2 : bus.rdata2;
        quo_fin      = (r.sign1 ^ r.sign2) ? -quo_last : quo_last;
        rem_fin      = r.sign1 ? -rem_last : rem_last;
    end

    always_comb begin
        rin       = r;
        rin.ready = 1'b0;
`ifdef DIV_EARLY_OUT_EN
        lz_groups = div_lzc(64'(dividend_abs), XLEN) / BITS_PER_CYCLE;
`endif
        unique case (r.state)
            StIdle: begin
                if (bus.enable) begin
                    rin.op      = bus.op;
                    rin.sign1   = !bus.op[0] && bus.rdata1[XLEN-1];
                    rin.sign2   = !bus.op[0] && bus.rdata2[XLEN-1];
                    rin.rem     = '0;
                    rin.quo     = dividend_abs;
                    rin.divisor = divisor_abs;
                    rin.cnt     = CntFull;
                    if (bus.rdata2 == '0) begin
                        rin.state  = StDone;
                        rin.ready  = 1'b1;
                        rin.result = bus.op[1] ? bus.rdata1 : '1;
                    end else if (!bus.op[0] && bus.rdata1 == MinNeg && bus.rdata2 == '1) begin
                        rin.state  = StDone;
                        rin.ready  = 1'b1;
                        rin.result = bus.op[1] ? '0 : bus.rdata1;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        if (dividend_abs == '0) begin
                            rin.state  = StDone;
                            rin.ready  = 1'b1;
                            rin.result = '0;
                        end else begin
                            // Nonzero dividend keeps lz_groups below Steps, so cnt stays >= 1.
                            rin.quo   = dividend_abs << (lz_groups * BITS_PER_CYCLE);
                            rin.cnt   = CntFull - CntW'(lz_groups);
                            rin.state = StBusy;
                        end
`else
                        rin.state = StBusy;
`endif
                    end
                end
            end
            StBusy: begin
                if (!bus.enable) begin
                    rin.state = StIdle;
                end else begin
                    rin.rem = rem_last;
                    rin.quo = quo_last;
                    rin.cnt = r.cnt - 1'b1;
                    if (r.cnt == CntW'(1)) begin
                        rin.state  = StDone;
                        rin.ready  = 1'b1;
                        rin.result = r.op[1] ? rem_fin : quo_fin;
                    end
                end
            end
            StDone: rin.state = StIdle;
            default: rin.state = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r <= init_div_reg;
        end else begin
            r <= rin;
        end
    end

    assign bus.result = r.result;
    assign bus.ready  = r.ready;
    assign bus.busy   = r.state != StIdle;
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: one XLEN=32 instance at 1 bit/cycle and one at 4 bits/cycle.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    div_iter_unit_if #(.XLEN(32)) bus1 ();
    div_iter_unit_if #(.XLEN(32)) bus4 ();

    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            bus4.enable = en; bus4.op = op; bus4.rdata1 = a; bus4.rdata2 = b;
        end else begin
            bus1.enable = en; bus1.op = op; bus1.rdata1 = a; bus1.rdata2 = b;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? bus4.ready : bus1.ready;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus4.busy : bus1.busy;
    endfunction

    function automatic logic [31:0] get_result(input bit sel);
        return sel ? bus4.result : bus1.result;
    endfunction

    // Advance one edge at a time until ready; n counts edges since the start sample.
    task automatic wait_ready(input bit sel, input int start, output int n);
        n = start;
        while (!get_ready(sel) && n <= 100) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input bit sel, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        drive(sel, 1'b1, op, a, b);
        @(posedge clock); #1;
        // Operands change after the start sample and must be ignored.
        drive(sel, 1'b1, op ^ 2'b01, ~a, ~b);
        check_eq({tag, "_busy"}, 64'(get_busy(sel)), 64'd1);
        wait_ready(sel, 1, n);
        check_eq({tag, "_lat"}, 64'(n), 64'(lat));
        check_eq({tag, "_res"}, 64'(get_result(sel)), 64'(exp));
        drive(sel, 1'b0, 2'b00, '0, '0);
        @(posedge clock); #1;
        check_eq({tag, "_pulse"}, {62'd0, get_ready(sel), get_busy(sel)}, 64'd0);
    endtask

    typedef struct {
        bit          sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat_def;
        int          lat_eo;
    } vec_t;

    vec_t vecs [18] = '{
        '{1'b0, div_op_div,  32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 33, 8},
        '{1'b0, div_op_rem,  32'd100,        32'hFFFFFFF9, 32'd2,        33, 8},
        '{1'b0, div_op_divu, 32'h80000000,   32'd0,        32'hFFFFFFFF, 1,  1},
        '{1'b0, div_op_remu, 32'd5,          32'd0,        32'd5,        1,  1},
        '{1'b0, div_op_div,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  1},
        '{1'b0, div_op_rem,  32'h80000000,   32'hFFFFFFFF, 32'd0,        1,  1},
        '{1'b0, div_op_div,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 33, 8},
        '{1'b0, div_op_rem,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 33, 8},
        '{1'b0, div_op_div,  32'h80000000,   32'd1,        32'h80000000, 33, 33},
        '{1'b0, div_op_rem,  32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, 1,  1},
        '{1'b0, div_op_div,  32'd5,          32'd0,        32'hFFFFFFFF, 1,  1},
        '{1'b0, div_op_remu, 32'hFFFFFFFF,   32'h10,       32'hF,        33, 33},
        '{1'b1, div_op_divu, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF, 9,  9},
        '{1'b1, div_op_divu, 32'd15,         32'd4,        32'd3,        9,  2},
        '{1'b1, div_op_divu, 32'd0,          32'd5,        32'd0,        9,  1},
        '{1'b1, div_op_rem,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 9,  2},
        '{1'b1, div_op_div,  32'd1000,       32'hFFFFFFFD, 32'hFFFFFEB3, 9,  4},
        '{1'b1, div_op_remu, 32'd1000,       32'd3,        32'd1,        9,  4}
    };

    initial begin
        logic [31:0] last1;
        int n;
        logic seen;

        last1 = '0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 1'b0, 2'b00, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_b1", {31'd0, bus1.result, bus1.ready, bus1.busy}, 64'd0);
        check_eq("rst_b4", {31'd0, bus4.result, bus4.ready, bus4.busy}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp, EarlyOut ? vecs[i].lat_eo : vecs[i].lat_def);
            if (!vecs[i].sel) last1 = vecs[i].exp;
        end

        // Abort DIVU 1000/3 in cycle 10, then restart as REMU.
        drive(1'b0, 1'b1, div_op_divu, 32'd1000, 32'd3);
        @(posedge clock); #1;
        n = 1;
        seen = 1'b0;
        while (n < 10) begin
            seen = seen | bus1.ready;
            @(posedge clock); #1;
            n++;
        end
        seen = seen | bus1.ready;
        check_eq("abort_busy10", 64'(bus1.busy), 64'd1);
        check_eq("abort_noready", 64'(seen), 64'd0);
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        @(posedge clock); #1;
        check_eq("abort_idle", {62'd0, bus1.ready, bus1.busy}, 64'd0);
        check_eq("abort_hold", 64'(bus1.result), 64'(last1));
        run_op("restart", 1'b0, div_op_remu, 32'd1000, 32'd3, 32'd1, EarlyOut ? 11 : 33);

        // Back-to-back with enable held through DONE.
        drive(1'b0, 1'b1, div_op_div, 32'd7, 32'd2);
        @(posedge clock); #1;
        wait_ready(1'b0, 1, n);
        check_eq("b2b_lat1", 64'(n), 64'(EarlyOut ? 4 : 33));
        check_eq("b2b_res1", 64'(bus1.result), 64'd3);
        drive(1'b0, 1'b1, div_op_rem, 32'hFFFFFFF9, 32'd2);
        @(posedge clock); #1;
        wait_ready(1'b0, 1, n);
        check_eq("b2b_gap", 64'(n), 64'(EarlyOut ? 5 : 34));
        check_eq("b2b_res2", 64'(bus1.result), 64'hFFFFFFFF);
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        @(posedge clock); #1;

        // Synchronous reset in the middle of an operation.
        drive(1'b0, 1'b1, div_op_divu, 32'hFFFFFFFF, 32'd3);
        repeat (5) @(posedge clock);
        #1;
        check_eq("midrst_busy", 64'(bus1.busy), 64'd1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b00, '0, '0);
        @(posedge clock); #1;
        check_eq("midrst_out", {31'd0, bus1.result, bus1.ready, bus1.busy}, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
